// File: rtl/axistream_if.sv
// axistream_if: AXI-Stream bundle with master and slave views
interface axistream_if #(
    parameter int DWIDTH     = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int BYTES      = (DWIDTH + 7) / 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DWIDTH-1:0]     tdata;
    logic [BYTES-1:0]      tstrb;
    logic [BYTES-1:0]      tkeep;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: fully registered AXI-Stream stage with a two-entry skid buffer.
// Define AXIS_SLICE_STATS_EN to add beat/packet/stall counters.
module axis_reg_slice #(
    parameter int DWIDTH     = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    localparam int BYTES     = (DWIDTH + 7) / 8
) (
    input logic aclk,
    input logic areset,
    axistream_if.slave  s_axis,
    axistream_if.master m_axis
`ifdef AXIS_SLICE_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [31:0] stat_beats,
    output logic [31:0] stat_pkts,
    output logic [31:0] stat_stalls
`endif
);
    localparam int BW = DWIDTH + 2 * BYTES + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t        state_q, state_n;
    logic          valid_q, rdy_q, s_hs, m_hs;
    logic [BW-1:0] s_beat, main_q, skid_q;

    assign s_beat = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                     s_axis.tid, s_axis.tdest, s_axis.tuser};
    assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
            m_axis.tid, m_axis.tdest, m_axis.tuser} = main_q;
    assign m_axis.tvalid = valid_q;
    assign s_axis.tready = rdy_q;

    always_comb begin
        s_hs    = s_axis.tvalid & rdy_q;
        m_hs    = valid_q & m_axis.tready;
        state_n = (state_q == EMPTY) ? (s_hs ? ONE : EMPTY) :
                  (state_q == ONE)   ? ((s_hs & ~m_hs) ? FULL : (~s_hs & m_hs) ? EMPTY : ONE) :
                                       (m_hs ? ONE : FULL);
    end

    // skid only captures the beat that arrives while the main register is stalled
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_n;
            valid_q <= state_n != EMPTY;
            rdy_q   <= state_n != FULL;
            if (s_hs && (state_q == EMPTY || m_hs))
                main_q <= s_beat;
            else if (state_q == FULL && m_hs)
                main_q <= skid_q;
            if (s_hs && state_q == ONE && !m_hs)
                skid_q <= s_beat;
        end
    end

`ifdef AXIS_SLICE_STATS_EN
    logic [31:0] beats_q, pkts_q, stalls_q;

    always_ff @(posedge aclk) begin
        if (areset || stats_clr) begin
            beats_q  <= '0;
            pkts_q   <= '0;
            stalls_q <= '0;
        end else begin
            beats_q  <= beats_q + 32'(m_hs);
            pkts_q   <= pkts_q + 32'(m_hs & m_axis.tlast);
            stalls_q <= stalls_q + 32'(valid_q & ~m_axis.tready);
        end
    end

    assign stat_beats  = beats_q;
    assign stat_pkts   = pkts_q;
    assign stat_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_axis_reg_slice.sv
// tb_axis_reg_slice: scoreboard bench for axis_reg_slice (stats checks under AXIS_SLICE_STATS_EN).
module tb_axis_reg_slice;
    localparam int DW = 32, IW = 4, DSW = 4, UW = 4, BY = 4;
    localparam int BW = DW + 2 * BY + IW + DSW + UW + 1;

    logic aclk = 1'b0, areset = 1'b1;
    always #5 aclk = ~aclk;

    axistream_if #(.DWIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) s_if ();
    axistream_if #(.DWIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) m_if ();

    logic [BW-1:0] s_beat = '0, m_beat;
    assign {s_if.tdata, s_if.tstrb, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser} = s_beat;
    assign m_beat = {m_if.tdata, m_if.tstrb, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};

`ifdef AXIS_SLICE_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] stat_beats, stat_pkts, stat_stalls;
`endif

    axis_reg_slice #(.DWIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis(s_if),
        .m_axis(m_if)
`ifdef AXIS_SLICE_STATS_EN
        ,
        .stats_clr(stats_clr),
        .stat_beats(stat_beats),
        .stat_pkts(stat_pkts),
        .stat_stalls(stat_stalls)
`endif
    );

    int total = 0, bad = 0, n_out = 0;
    logic [BW-1:0] q[$];
    logic pv = 1'b0, pr = 1'b0;
    logic [BW-1:0] pb = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic [31:0] d, input logic l);
        return {d, 4'hF, 4'hF, l, 4'h1, 4'h2, 4'h3};
    endfunction

    // sampled mid-cycle, so values reflect what the next rising edge will see
    always @(negedge aclk) begin
        if (areset) begin
            q.delete();
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_v", 64'(m_if.tvalid), 64'd1);
                check("hold_b", 64'(m_beat), 64'(pb));
            end
            if (m_if.tvalid && m_if.tready) begin
                n_out++;
                if (q.size() == 0) check("extra", 64'd1, 64'd0);
                else check("beat", 64'(m_beat), 64'(q.pop_front()));
            end
            if (s_if.tvalid && s_if.tready) q.push_back(s_beat);
            pv = m_if.tvalid;
            pr = m_if.tready;
            pb = m_beat;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic put(input logic [BW-1:0] b);
        logic hs;
        int n;
        s_beat = b;
        s_if.tvalid = 1'b1;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 100) begin
            hs = s_if.tready;
            tick();
            n++;
        end
        if (!hs) check("put_to", 64'd0, 64'd1);
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        while ((q.size() != 0 || m_if.tvalid) && n < 50) begin
            tick();
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
        check("drain_v", 64'(m_if.tvalid), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, cyc, n0;
        logic pend, hs;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        tick();
        tick();
        check("rst_v", 64'(m_if.tvalid), 64'd0);
        check("rst_r", 64'(s_if.tready), 64'd0);
        check("rst_d", 64'(m_beat), 64'd0);
        areset = 1'b0;
        tick();
        check("rel_r", 64'(s_if.tready), 64'd1);
        check("rel_v", 64'(m_if.tvalid), 64'd0);

        m_if.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_beat = {32'(i), 4'($urandom), 4'($urandom), i == 15, 12'($urandom)};
            s_if.tvalid = 1'b1;
            check("pt_rdy", 64'(s_if.tready), 64'd1);
            tick();
            check("pt_v", 64'(m_if.tvalid), 64'd1);
            check("pt_d", 64'(m_if.tdata), 64'(i));
        end
        check("pt_last", 64'(m_if.tlast), 64'd1);
        drain();

        m_if.tready = 1'b0;
        s_beat = mk(32'hA1, 1'b0);
        s_if.tvalid = 1'b1;
        tick();
        s_beat = mk(32'hA2, 1'b1);
        check("sk_rdy1", 64'(s_if.tready), 64'd1);
        tick();
        s_if.tvalid = 1'b0;
        check("sk_full", 64'(s_if.tready), 64'd0);
        check("sk_d1", 64'(m_if.tdata), 64'hA1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sk_hold", 64'(m_if.tdata), 64'hA1);
            check("sk_stay", 64'(s_if.tready), 64'd0);
        end
        m_if.tready = 1'b1;
        tick();
        check("sk_d2", 64'(m_if.tdata), 64'hA2);
        check("sk_rdy2", 64'(s_if.tready), 64'd1);
        tick();
        check("sk_empty", 64'(m_if.tvalid), 64'd0);

        sent = 0;
        cyc = 0;
        pend = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!pend) begin
                s_beat = {$urandom, 4'($urandom), 4'($urandom), 1'($urandom), 12'($urandom)};
                s_if.tvalid = 1'($urandom_range(1));
                pend = s_if.tvalid;
            end
            m_if.tready = 1'($urandom_range(1));
            hs = s_if.tvalid && s_if.tready;
            tick();
            cyc++;
            if (hs) begin
                pend = 1'b0;
                sent++;
            end
        end
        check("rand_sent", 64'(sent), 64'd10000);
        drain();

        m_if.tready = 1'b0;
        s_beat = mk(32'hB1, 1'b0);
        s_if.tvalid = 1'b1;
        tick();
        s_beat = mk(32'hB2, 1'b0);
        tick();
        s_if.tvalid = 1'b0;
        check("mr_full", 64'(s_if.tready), 64'd0);
        areset = 1'b1;
        tick();
        check("mr_v", 64'(m_if.tvalid), 64'd0);
        check("mr_r", 64'(s_if.tready), 64'd0);
        check("mr_d", 64'(m_beat), 64'd0);
        areset = 1'b0;
        tick();
        check("mr_rel", 64'(s_if.tready), 64'd1);
        n0 = n_out;
        m_if.tready = 1'b1;
        put(mk(32'h55, 1'b1));
        check("mr_55", 64'(m_if.tdata), 64'h55);
        drain();
        check("mr_cnt", 64'(n_out - n0), 64'd1);

`ifdef AXIS_SLICE_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            put(mk(32'(i), (i % 4) == 3));
            if (i < 5) begin
                m_if.tready = 1'b0;
                tick();
                m_if.tready = 1'b1;
            end
            tick();
        end
        check("st_beats", 64'(stat_beats), 64'd12);
        check("st_pkts", 64'(stat_pkts), 64'd3);
        check("st_stalls", 64'(stat_stalls), 64'd5);
        put(mk(32'h77, 1'b1));
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("clr_beats", 64'(stat_beats), 64'd0);
        check("clr_pkts", 64'(stat_pkts), 64'd0);
        check("clr_stalls", 64'(stat_stalls), 64'd0);
        force dut.beats_q = 32'hFFFFFFFF;
        tick();
        release dut.beats_q;
        check("wrap_pre", 64'(stat_beats), 64'hFFFFFFFF);
        put(mk(32'h1, 1'b0));
        tick();
        check("wrap", 64'(stat_beats), 64'd0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
